// File: rtl/bout_sequencer.sv
// Match-level bout controller: ready -> countdown -> fencing -> touch hold -> match over.
// Optional feature macro: BOUT_DOUBLE_TOUCH_EN (simultaneous touch scores for both sides).
module bout_sequencer #(
  parameter int WIN_SCORE    = 5,
  parameter int COUNT_FRAMES = 60,
  parameter int HOLD_FRAMES  = 120
) (
  input  logic       clk_pixel_in,
  input  logic       rst_n_in,
  input  logic       self_started_in,
  input  logic       opponent_started_in,
  input  logic       frame_tick_in,
  input  logic       score_valid_in,
  input  logic       player_scored_in,
  input  logic       opponent_scored_in,
  input  logic       rematch_in,
  output logic [2:0] state_out,
  output logic [1:0] countdown_out,
  output logic       actions_enable_out,
  output logic       positions_reset_out,
  output logic [3:0] player_score_out,
  output logic [3:0] opponent_score_out,
  output logic [1:0] winner_out
);

  typedef enum logic [2:0] {
    S_WAIT_READY = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FENCING    = 3'd2,
    S_TOUCH_HOLD = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  // One shared frame counter serves both countdown steps and the touch hold.
  localparam int CNT_MAX = (COUNT_FRAMES > HOLD_FRAMES) ? COUNT_FRAMES : HOLD_FRAMES;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  localparam logic [1:0] WINNER_NONE     = 2'd0;
  localparam logic [1:0] WINNER_PLAYER   = 2'd1;
  localparam logic [1:0] WINNER_OPPONENT = 2'd2;
  localparam logic [1:0] WINNER_TIE      = 2'd3;

  state_t        r_state;
  logic [1:0]    r_countdown;
  logic [CW-1:0] r_frame_cnt;
  logic [3:0]    r_player_score;
  logic [3:0]    r_opponent_score;
  logic [1:0]    r_winner;
  logic          r_actions_enable;
  logic          r_positions_reset;

  state_t        w_state_next;
  logic [1:0]    w_countdown_next;
  logic [CW-1:0] w_frame_cnt_next;
  logic [3:0]    w_player_score_next;
  logic [3:0]    w_opponent_score_next;
  logic [1:0]    w_winner_next;
  logic          w_positions_reset_next;

  logic          w_both_started;
  logic          w_touch;
  logic          w_player_award;
  logic          w_opponent_award;
  logic [3:0]    w_player_score_inc;
  logic [3:0]    w_opponent_score_inc;
  logic          w_player_won;
  logic          w_opponent_won;
  logic [1:0]    w_winner_calc;

  assign w_both_started = self_started_in && opponent_started_in;
  assign w_touch        = score_valid_in && (player_scored_in || opponent_scored_in);

`ifdef BOUT_DOUBLE_TOUCH_EN
  assign w_player_award   = player_scored_in;
  assign w_opponent_award = opponent_scored_in;
`else
  // A double touch cancels out: the hold and countdown still run, nobody scores.
  assign w_player_award   = player_scored_in && !opponent_scored_in;
  assign w_opponent_award = opponent_scored_in && !player_scored_in;
`endif

  assign w_player_score_inc   = (r_player_score < WIN) ? r_player_score + 4'd1 : r_player_score;
  assign w_opponent_score_inc = (r_opponent_score < WIN) ? r_opponent_score + 4'd1 : r_opponent_score;

  assign w_player_won   = (r_player_score == WIN);
  assign w_opponent_won = (r_opponent_score == WIN);

  always_comb begin
    w_winner_calc = WINNER_NONE;
    if (w_player_won && w_opponent_won) begin
      w_winner_calc = WINNER_TIE;
    end else if (w_player_won) begin
      w_winner_calc = WINNER_PLAYER;
    end else if (w_opponent_won) begin
      w_winner_calc = WINNER_OPPONENT;
    end
  end

  always_comb begin
    w_state_next           = r_state;
    w_countdown_next       = r_countdown;
    w_frame_cnt_next       = r_frame_cnt;
    w_player_score_next    = r_player_score;
    w_opponent_score_next  = r_opponent_score;
    w_winner_next          = r_winner;
    w_positions_reset_next = 1'b0;

    if (r_state != S_MATCH_OVER && !w_both_started) begin
      // Losing either player aborts the exchange but keeps the score.
      w_state_next     = S_WAIT_READY;
      w_countdown_next = 2'd0;
      w_frame_cnt_next = '0;
    end else begin
      case (r_state)
        S_WAIT_READY: begin
          w_state_next           = S_COUNTDOWN;
          w_countdown_next       = 2'd3;
          w_frame_cnt_next       = '0;
          w_positions_reset_next = 1'b1;
        end

        S_COUNTDOWN: begin
          if (frame_tick_in) begin
            if (r_frame_cnt == COUNT_LAST) begin
              w_frame_cnt_next = '0;
              if (r_countdown == 2'd1) begin
                w_state_next     = S_FENCING;
                w_countdown_next = 2'd0;
              end else begin
                w_countdown_next = r_countdown - 2'd1;
              end
            end else begin
              w_frame_cnt_next = r_frame_cnt + CW'(1);
            end
          end
        end

        S_FENCING: begin
          if (w_touch) begin
            w_state_next     = S_TOUCH_HOLD;
            w_frame_cnt_next = '0;
            if (w_player_award) begin
              w_player_score_next = w_player_score_inc;
            end
            if (w_opponent_award) begin
              w_opponent_score_next = w_opponent_score_inc;
            end
          end
        end

        S_TOUCH_HOLD: begin
          if (frame_tick_in) begin
            if (r_frame_cnt == HOLD_LAST) begin
              w_frame_cnt_next = '0;
              if (w_player_won || w_opponent_won) begin
                w_state_next  = S_MATCH_OVER;
                w_winner_next = w_winner_calc;
              end else begin
                w_state_next           = S_COUNTDOWN;
                w_countdown_next       = 2'd3;
                w_positions_reset_next = 1'b1;
              end
            end else begin
              w_frame_cnt_next = r_frame_cnt + CW'(1);
            end
          end
        end

        S_MATCH_OVER: begin
          if (rematch_in) begin
            w_state_next          = S_WAIT_READY;
            w_frame_cnt_next      = '0;
            w_player_score_next   = 4'd0;
            w_opponent_score_next = 4'd0;
            w_winner_next         = WINNER_NONE;
          end
        end

        default: begin
          w_state_next     = S_WAIT_READY;
          w_countdown_next = 2'd0;
          w_frame_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state           <= S_WAIT_READY;
      r_countdown       <= 2'd0;
      r_frame_cnt       <= '0;
      r_player_score    <= 4'd0;
      r_opponent_score  <= 4'd0;
      r_winner          <= WINNER_NONE;
      r_actions_enable  <= 1'b0;
      r_positions_reset <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_countdown       <= w_countdown_next;
      r_frame_cnt       <= w_frame_cnt_next;
      r_player_score    <= w_player_score_next;
      r_opponent_score  <= w_opponent_score_next;
      r_winner          <= w_winner_next;
      // Drops on the same edge a touch is registered, so no later action slips in.
      r_actions_enable  <= (w_state_next == S_FENCING);
      r_positions_reset <= w_positions_reset_next;
    end
  end

  assign state_out           = r_state;
  assign countdown_out       = r_countdown;
  assign actions_enable_out  = r_actions_enable;
  assign positions_reset_out = r_positions_reset;
  assign player_score_out    = r_player_score;
  assign opponent_score_out  = r_opponent_score;
  assign winner_out          = r_winner;

endmodule

// File: tb/tb_bout_sequencer.sv
// Bench for bout_sequencer: directed scenarios plus randomized run against a tick-counting reference model.
module tb_bout_sequencer;
  localparam int WIN = 4;
  localparam int CF  = 2;
  localparam int HF  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic self_st = 1'b0, opp_st = 1'b0, tick = 1'b0;
  logic sv = 1'b0, ps_in = 1'b0, os_in = 1'b0, rematch = 1'b0;

  logic [2:0] state;
  logic [1:0] cd;
  logic       en, prst;
  logic [3:0] pscore, oscore;
  logic [1:0] winner;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase number, ticks seen in the phase, scores, winner, reset pulse.
  int m_state = 0, m_ticks = 0, m_ps = 0, m_os = 0, m_win = 0, m_prst = 0;

  always #5 clk = ~clk;

  bout_sequencer #(.WIN_SCORE(WIN), .COUNT_FRAMES(CF), .HOLD_FRAMES(HF)) dut (
    .clk_pixel_in        (clk),
    .rst_n_in            (rst_n),
    .self_started_in     (self_st),
    .opponent_started_in (opp_st),
    .frame_tick_in       (tick),
    .score_valid_in      (sv),
    .player_scored_in    (ps_in),
    .opponent_scored_in  (os_in),
    .rematch_in          (rematch),
    .state_out           (state),
    .countdown_out       (cd),
    .actions_enable_out  (en),
    .positions_reset_out (prst),
    .player_score_out    (pscore),
    .opponent_score_out  (oscore),
    .winner_out          (winner)
  );

  function automatic int m_cd();
    return (m_state == 1) ? 3 - (m_ticks / CF) : 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ticks = 0; m_ps = 0; m_os = 0; m_win = 0; m_prst = 0;
  endtask

  task automatic model_update();
    m_prst = 0;
    if (m_state != 4 && !(self_st && opp_st)) begin
      m_state = 0;
      m_ticks = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_ticks = 0; m_prst = 1; end
        1: if (tick) begin
             m_ticks++;
             if (m_ticks == 3 * CF) begin m_state = 2; m_ticks = 0; end
           end
        2: if (sv && (ps_in || os_in)) begin
             if (ps_in && os_in) begin
`ifdef BOUT_DOUBLE_TOUCH_EN
               if (m_ps < WIN) m_ps++;
               if (m_os < WIN) m_os++;
`endif
             end else if (ps_in) begin
               if (m_ps < WIN) m_ps++;
             end else begin
               if (m_os < WIN) m_os++;
             end
             m_state = 3;
             m_ticks = 0;
           end
        3: if (tick) begin
             m_ticks++;
             if (m_ticks == HF) begin
               m_ticks = 0;
               if (m_ps == WIN || m_os == WIN) begin
                 m_win = (m_ps == WIN && m_os == WIN) ? 3 : (m_ps == WIN) ? 1 : 2;
                 m_state = 4;
               end else begin
                 m_state = 1;
                 m_prst = 1;
               end
             end
           end
        4: if (rematch) begin m_ps = 0; m_os = 0; m_win = 0; m_state = 0; end
        default: ;
      endcase
    end
  endtask

  // One clock: the model consumes the same inputs the DUT samples, then outputs settle.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_countdown();
    for (int i = 0; i < 3 * CF; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
  endtask

  task automatic do_touch(input logic p, input logic o);
    sv = 1'b1; ps_in = p; os_in = o;
    step();
    sv = 1'b0; ps_in = 1'b0; os_in = 1'b0;
    for (int i = 0; i < HF; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
    if (m_state == 1) run_countdown();
  endtask

  task automatic test_reset();
    #12;
    n_total++;
    if ({state, cd, en, prst, pscore, oscore, winner} !== 17'd0) begin
      $display("FAIL reset_outputs got %h want 0", {state, cd, en, prst, pscore, oscore, winner});
    end else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_start();
    self_st = 1'b1;
    repeat (3) step();
    n_total++;
    if (state !== 3'd0) $display("FAIL one_started_state got %0d want 0", state); else n_pass++;
    opp_st = 1'b1;
    step();
    n_total++;
    if (state !== 3'd1 || cd !== 2'd3 || prst !== 1'b1)
      $display("FAIL start_entry got state=%0d cd=%0d prst=%0d want 1 3 1", state, cd, prst);
    else n_pass++;
    step();
    n_total++;
    if (prst !== 1'b0 || state !== 3'd1) $display("FAIL start_pulse_width got prst=%0d state=%0d want 0 1", prst, state);
    else n_pass++;
  endtask

  task automatic test_countdown();
    for (int i = 1; i <= 3 * CF; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (i < 3 * CF) begin
        n_total++;
        if (cd !== 2'(3 - i / CF)) $display("FAIL countdown_digit tick=%0d got %0d want %0d", i, cd, 3 - i / CF);
        else n_pass++;
        step();
      end
    end
    n_total++;
    if (state !== 3'd2 || en !== 1'b1 || cd !== 2'd0)
      $display("FAIL countdown_end got state=%0d en=%0d cd=%0d want 2 1 0", state, en, cd);
    else n_pass++;
  endtask

  task automatic test_touch();
    // The tick coinciding with the touch must not count toward the hold.
    sv = 1'b1; ps_in = 1'b1; tick = 1'b1;
    step();
    sv = 1'b0; ps_in = 1'b0; tick = 1'b0;
    n_total++;
    if (pscore !== 4'd1 || oscore !== 4'd0 || state !== 3'd3 || en !== 1'b0)
      $display("FAIL touch_entry got ps=%0d os=%0d state=%0d en=%0d want 1 0 3 0", pscore, oscore, state, en);
    else n_pass++;
    for (int i = 0; i < HF; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      if (i < HF - 1) begin
        n_total++;
        if (state !== 3'd3) $display("FAIL hold_length tick=%0d got %0d want 3", i + 1, state); else n_pass++;
      end
    end
    n_total++;
    if (state !== 3'd1 || prst !== 1'b1 || cd !== 2'd3)
      $display("FAIL hold_exit got state=%0d prst=%0d cd=%0d want 1 1 3", state, prst, cd);
    else n_pass++;
  endtask

  task automatic test_abort();
    tick = 1'b1; step(); step(); tick = 1'b0;
    opp_st = 1'b0;
    step();
    n_total++;
    if (state !== 3'd0 || cd !== 2'd0 || pscore !== 4'd1)
      $display("FAIL abort got state=%0d cd=%0d ps=%0d want 0 0 1", state, cd, pscore);
    else n_pass++;
    opp_st = 1'b1;
    step();
    n_total++;
    if (state !== 3'd1 || cd !== 2'd3 || prst !== 1'b1)
      $display("FAIL restart got state=%0d cd=%0d prst=%0d want 1 3 1", state, cd, prst);
    else n_pass++;
  endtask

  task automatic test_win_rematch();
    run_countdown();
    repeat (WIN) do_touch(1'b0, 1'b1);
    n_total++;
    if (state !== 3'd4 || winner !== 2'd2 || oscore !== 4'(WIN) || pscore !== 4'd1 || en !== 1'b0)
      $display("FAIL opp_win got state=%0d win=%0d os=%0d ps=%0d en=%0d want 4 2 %0d 1 0", state, winner, oscore, pscore, en, WIN);
    else n_pass++;
    sv = 1'b1; ps_in = 1'b1; tick = 1'b1;
    repeat (3) step();
    sv = 1'b0; ps_in = 1'b0; tick = 1'b0;
    n_total++;
    if (state !== 3'd4 || pscore !== 4'd1) $display("FAIL match_over_hold got state=%0d ps=%0d want 4 1", state, pscore);
    else n_pass++;
    rematch = 1'b1; step(); rematch = 1'b0;
    n_total++;
    if (state !== 3'd0 || pscore !== 4'd0 || oscore !== 4'd0 || winner !== 2'd0)
      $display("FAIL rematch got state=%0d ps=%0d os=%0d win=%0d want 0 0 0 0", state, pscore, oscore, winner);
    else n_pass++;
    step();
    n_total++;
    if (state !== 3'd1 || prst !== 1'b1) $display("FAIL rematch_restart got state=%0d prst=%0d want 1 1", state, prst);
    else n_pass++;
  endtask

  task automatic test_double_touch();
    run_countdown();
    repeat (WIN - 1) do_touch(1'b1, 1'b0);
    repeat (WIN - 1) do_touch(1'b0, 1'b1);
    sv = 1'b1; ps_in = 1'b1; os_in = 1'b1;
    step();
    sv = 1'b0; ps_in = 1'b0; os_in = 1'b0;
    for (int i = 0; i < HF; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
    end
`ifdef BOUT_DOUBLE_TOUCH_EN
    n_total++;
    if (pscore !== 4'(WIN) || oscore !== 4'(WIN) || state !== 3'd4 || winner !== 2'd3)
      $display("FAIL double_touch got ps=%0d os=%0d state=%0d win=%0d want %0d %0d 4 3", pscore, oscore, state, winner, WIN, WIN);
    else n_pass++;
    rematch = 1'b1; step(); rematch = 1'b0;
`else
    n_total++;
    if (pscore !== 4'(WIN - 1) || oscore !== 4'(WIN - 1) || state !== 3'd1 || winner !== 2'd0)
      $display("FAIL double_touch got ps=%0d os=%0d state=%0d win=%0d want %0d %0d 1 0", pscore, oscore, state, winner, WIN - 1, WIN - 1);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    run_countdown();
    repeat (3) do_touch(1'b1, 1'b0);
    do_touch(1'b0, 1'b1);
    n_total++;
    if (state !== 3'd2 || pscore !== 4'd3 || oscore !== 4'd1)
      $display("FAIL setup_3_1 got state=%0d ps=%0d os=%0d want 2 3 1", state, pscore, oscore);
    else n_pass++;
    // Clock is high here; the next edge is a negedge, so any change must be asynchronous.
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({state, cd, en, prst, pscore, oscore, winner} !== 17'd0)
      $display("FAIL async_reset got %h want 0", {state, cd, en, prst, pscore, oscore, winner});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      self_st = ($urandom_range(0, 99) >= 2);
      opp_st  = ($urandom_range(0, 99) >= 2);
      tick    = 1'($urandom_range(0, 1));
      sv      = ($urandom_range(0, 99) < 15);
      ps_in   = 1'($urandom_range(0, 1));
      os_in   = 1'($urandom_range(0, 1));
      rematch = ($urandom_range(0, 99) < 5);
      step();
      n_total++;
      if (state !== 3'(m_state)) $display("FAIL rnd_state cyc=%0d got %0d want %0d", c, state, m_state); else n_pass++;
      n_total++;
      if (cd !== 2'(m_cd())) $display("FAIL rnd_countdown cyc=%0d got %0d want %0d", c, cd, m_cd()); else n_pass++;
      n_total++;
      if (en !== (m_state == 2)) $display("FAIL rnd_enable cyc=%0d got %0d want %0d", c, en, m_state == 2); else n_pass++;
      n_total++;
      if (prst !== 1'(m_prst)) $display("FAIL rnd_pos_reset cyc=%0d got %0d want %0d", c, prst, m_prst); else n_pass++;
      n_total++;
      if (pscore !== 4'(m_ps)) $display("FAIL rnd_player_score cyc=%0d got %0d want %0d", c, pscore, m_ps); else n_pass++;
      n_total++;
      if (oscore !== 4'(m_os)) $display("FAIL rnd_opp_score cyc=%0d got %0d want %0d", c, oscore, m_os); else n_pass++;
      n_total++;
      if (winner !== 2'(m_win)) $display("FAIL rnd_winner cyc=%0d got %0d want %0d", c, winner, m_win); else n_pass++;
    end
    sv = 1'b0; tick = 1'b0; rematch = 1'b0; ps_in = 1'b0; os_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_countdown();
    test_touch();
    test_abort();
    test_win_rematch();
    test_double_touch();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bout_sequencer.md
# bout_sequencer

Match-level controller for the fencing game: it sequences a bout from "both players ready" through countdown, active fencing, touch hold and match end. It consumes the local/opponent start flags and the per-exchange scoring results produced by the action/sync datapath. It gates when remote actions are accepted, requests position resets between touches, and keeps the authoritative score and winner for the display layer. Runs entirely in the pixel clock domain.

## Interface
Parameters:
- WIN_SCORE, default 5: touches needed to win; scores saturate here.
- COUNT_FRAMES, default 60: frame ticks per countdown step.
- HOLD_FRAMES, default 120: frame ticks spent in touch hold.

Ports:
- clk_pixel_in  input  1  pixel clock.
- rst_n_in  input  1  reset; asynchronous, active-low.
- self_started_in  input  1  local player has pressed start (level).
- opponent_started_in  input  1  remote player has started (level).
- frame_tick_in  input  1  one-cycle pulse per video frame.
- score_valid_in  input  1  one-cycle pulse: exchange result valid.
- player_scored_in  input  1  local player landed a touch (qualified by score_valid_in).
- opponent_scored_in  input  1  opponent landed a touch (qualified by score_valid_in).
- rematch_in  input  1  one-cycle pulse requesting a new match.
- state_out  output  3  current state encoding.
- countdown_out  output  2  countdown digit 3..1; 0 outside COUNTDOWN.
- actions_enable_out  output  1  high only in FENCING; gates IR actions.
- positions_reset_out  output  1  one-cycle pulse: return fencers to en garde.
- player_score_out  output  4  local score.
- opponent_score_out  output  4  opponent score.
- winner_out  output  2  0 none, 1 player, 2 opponent, 3 tie.

## Operation
- States: WAIT_READY=0, COUNTDOWN=1, FENCING=2, TOUCH_HOLD=3, MATCH_OVER=4.
- WAIT_READY: when self_started_in && opponent_started_in, load countdown 3, clear frame counter, pulse positions_reset_out, go COUNTDOWN.
- COUNTDOWN: count frame_tick_in; after COUNT_FRAMES ticks, decrement digit; when the digit would go from 1 to 0, go FENCING.
- FENCING: on score_valid_in with at least one scored flag set, update scores and go TOUCH_HOLD. score_valid_in with neither flag set is ignored.
- Score update: each flagged side +1, saturating at WIN_SCORE. Simultaneous flags = double touch; handling depends on configuration.
- TOUCH_HOLD: count HOLD_FRAMES ticks, then:
  - if either score == WIN_SCORE, set winner_out (player, opponent, or tie if both) and go MATCH_OVER;
  - otherwise pulse positions_reset_out, load countdown 3 and go COUNTDOWN.
- MATCH_OVER: outputs hold. rematch_in clears scores and winner, then goes WAIT_READY.
- In any state except MATCH_OVER, if either start flag is low, go WAIT_READY. Scores are kept.
- score_valid_in is ignored outside FENCING. rematch_in is ignored outside MATCH_OVER.

## Timing
- Reset (async assert, sync release): state WAIT_READY, countdown 0, all scores/winner 0, actions_enable_out 0, positions_reset_out 0, frame counter 0.
- All outputs are registered. State and outputs change on the clk_pixel_in edge after the causing input is sampled (latency 1).
- Score registers and the TOUCH_HOLD entry update in the same cycle. actions_enable_out drops that same edge, so no further actions are accepted.
- The countdown digit changes on the edge after the COUNT_FRAMES-th tick. Total countdown is 3*COUNT_FRAMES ticks.
- frame_tick_in coincident with a state transition is not counted toward the new state. Counters clear on every state entry.
- Reset asserted mid-bout aborts immediately. There is no score retention across reset.

## Configuration
- BOUT_DOUBLE_TOUCH_EN defined: a simultaneous touch awards both sides +1. Both reaching WIN_SCORE yields winner_out=3.
- Not defined: a simultaneous touch awards no points but still enters TOUCH_HOLD and re-runs the countdown. winner_out=3 is unreachable.

## Test plan
- Reset, raise only self_started_in → stays WAIT_READY. Raise opponent_started_in → state 1, countdown_out 3, one positions_reset_out pulse.
- COUNT_FRAMES=2: feed 6 ticks → countdown 3,2,1, then state 2 with actions_enable_out=1 on the edge after tick 6.
- In FENCING, score_valid_in with player_scored_in only → player_score_out 1, state 3. After HOLD_FRAMES ticks → positions_reset_out pulse and state 1.
- WIN_SCORE=2: opponent scores twice → after the hold, state 4 and winner_out=2. Then rematch_in → scores 0, winner 0, state 0 → countdown.
- Double touch at 1–1, WIN_SCORE=2: with BOUT_DOUBLE_TOUCH_EN → 2–2, winner_out=3. Without it → stays 1–1 and returns to COUNTDOWN.
- Assert rst_n_in low during FENCING with score 3–1 → all outputs 0 and state 0 immediately, without waiting for a clock edge.
